fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and fetch-sequencing stage that sits directly upstream of the control decoder: it drives the instruction-ROM address and consumes the decoder's Jump/BranchEn/Imm outputs plus the ALU branch flag to select the next PC. It also runs the program start/halt handshake with the test harness and counts retired instructions for dynamic-count reporting.

## Interface
Parameters:
- PW, 10, program-counter / instruction-ROM address width
- CW, 16, retired-instruction counter width

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low; sampled on rising Clk
- Start  in  1  single-cycle pulse from harness; begins a program run
- StartAddr  in  PW  PC loaded when Start accepted
- Jump  in  1  decoder: unconditional jump this cycle
- BranchEn  in  1  decoder: current instruction is a conditional branch
- BranchTaken  in  1  ALU flag: branch condition true
- Imm  in  5  decoder immediate; LUT index for jump/branch
- Halt  in  1  decoder: current instruction is HALT
- Stall  in  1  hold PC this cycle (multi-cycle memory op)
- ProgCtr  out  PW  registered PC, drives instruction ROM
- Running  out  1  high in RUN state
- Done  out  1  high in HALTED state
- InstrCount  out  CW  retired instructions since last accepted Start

## Operation
- FSM states: IDLE, RUN, HALTED. Reset low -> IDLE, ProgCtr=0, InstrCount=0, Running=0, Done=0.
- IDLE: Start=1 -> RUN, ProgCtr<=StartAddr, InstrCount<=0. Start=0 -> stay; all outputs hold.
- RUN, next-PC priority (highest first): Halt -> go HALTED, PC holds; Stall -> PC holds; Jump -> PC<=JUMP_LUT[Imm]; BranchEn&&BranchTaken -> PC<=PC+1+BR_OFS[Imm[2:0]]; else PC<=PC+1.
- BranchEn with BranchTaken=0 -> PC+1. BranchTaken ignored when BranchEn=0.
- Start in RUN ignored.
- HALTED: PC and InstrCount hold, Done=1. Start=1 -> RUN, PC<=StartAddr, InstrCount<=0, Done falls next edge.
- InstrCount increments by 1 on each RUN cycle with Stall=0 or Halt=1 (HALT counts once); saturates at all-ones, no wrap.
- PC arithmetic modulo 2^PW: PC=2^PW-1 increments to 0; negative branch offsets wrap likewise. BR_OFS entries are signed, sign-extended to PW.
- Reset low mid-run overrides everything, including Start and Halt in the same cycle.

## Timing
- Zero-latency decode loop: ROM read of ProgCtr, decode, and flag evaluation are combinational in the same cycle; the new PC appears after the next rising edge. No delay slots.
- Start accepted on the edge where it is sampled high in IDLE/HALTED; first fetch address valid the following cycle.
- Halt sampled in RUN -> Running=0, Done=1 from the next cycle.
- Jump, BranchEn, Halt, Imm are don't-care outside RUN.
- All outputs registered or decoded directly from registered state; no combinational input-to-output path.

## Structure
- Shared package: fetch FSM state enum (IDLE/RUN/HALTED), JUMP_LUT (32 x PW absolute targets), BR_OFS (8 x signed PW offsets). Package values used by the bench: JUMP_LUT[3]=100, BR_OFS[1]=-4, BR_OFS[2]=+6.
- One sub-module: target_lut (combinational; Imm in, jump target and branch offset out) so tables can be regenerated by the assembler flow without touching the FSM.

## Test plan
- Reset low for 2 cycles mid-run at PC=57 -> ProgCtr=0, Running=0, Done=0, InstrCount=0; Start with StartAddr=0 -> PC 0,1,2,3 on successive cycles, Running=1.
- In RUN at PC=20, Jump=1, Imm=3 -> PC=100 next cycle; at PC=40, BranchEn=1, BranchTaken=1, Imm=1 -> PC=37; same with BranchTaken=0 -> PC=41.
- Stall high for 3 cycles at PC=10 -> PC holds 10, InstrCount unchanged; Stall with Jump=1 -> no jump.
- Halt at PC=15 after 16 retired instructions -> Done=1, Running=0, PC=15, InstrCount=17 (HALT counted); Start with StartAddr=200 -> PC=200, InstrCount=0, Done=0.
- StartAddr=1022, no control -> PC 1022, 1023, 0, 1; at PC=1, BranchEn&&BranchTaken, Imm=1 -> PC=1022.
- Same-cycle Halt, Stall and Jump -> HALTED, PC unchanged; Start pulse while Running -> ignored, PC keeps incrementing.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch FSM state type and jump/branch target tables
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   // Table entries are stored at the native 10-bit PC width; target_lut resizes them.
   localparam int LUT_W = 10;

   function automatic logic [LUT_W-1:0] jump_lut(input logic [4:0] idx);
      logic [LUT_W-1:0] tgt;
      case (idx)
         5'd0:    tgt = 10'd0;
         5'd1:    tgt = 10'd16;
         5'd2:    tgt = 10'd48;
         5'd3:    tgt = 10'd100;
         5'd4:    tgt = 10'd128;
         5'd5:    tgt = 10'd200;
         5'd6:    tgt = 10'd256;
         5'd7:    tgt = 10'd300;
         default: tgt = {idx, 5'd0};
      endcase
      return tgt;
   endfunction

   function automatic logic signed [LUT_W-1:0] br_ofs(input logic [2:0] idx);
      logic signed [LUT_W-1:0] ofs;
      case (idx)
         3'd0:    ofs = 10'sd2;
         3'd1:    ofs = -10'sd4;
         3'd2:    ofs = 10'sd6;
         3'd3:    ofs = -10'sd1;
         3'd4:    ofs = 10'sd8;
         3'd5:    ofs = -10'sd8;
         3'd6:    ofs = 10'sd16;
         default: ofs = -10'sd16;
      endcase
      return ofs;
   endfunction

endpackage

// File: rtl/fetch_unit_target_lut.sv
// rtl/fetch_unit_target_lut.sv - combinational Imm to jump target / branch offset lookup
module target_lut
   import fetch_unit_pkg::*;
#(
   parameter int PW = 10
) (
   input  logic [4:0]    imm,
   output logic [PW-1:0] jump_target,
   output logic [PW-1:0] branch_ofs
);

   logic [LUT_W-1:0]        jump_raw;
   logic signed [LUT_W-1:0] ofs_raw;

   always_comb begin
      jump_raw    = jump_lut(imm);
      ofs_raw     = br_ofs(imm[2:0]);
      // Signed source so widening to PW sign-extends the offset.
      jump_target = PW'(jump_raw);
      branch_ofs  = PW'(ofs_raw);
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, start/halt sequencing and retired-instruction count
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int PW = 10,
   parameter int CW = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [PW-1:0] StartAddr,
   input  logic          Jump,
   input  logic          BranchEn,
   input  logic          BranchTaken,
   input  logic [4:0]    Imm,
   input  logic          Halt,
   input  logic          Stall,
   output logic [PW-1:0] ProgCtr,
   output logic          Running,
   output logic          Done,
   output logic [CW-1:0] InstrCount
);

   fetch_state_e  state_q, state_d;
   logic [PW-1:0] pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] jump_target;
   logic [PW-1:0] branch_ofs;

   target_lut #(.PW(PW)) u_target_lut (
      .imm         (Imm),
      .jump_target (jump_target),
      .branch_ofs  (branch_ofs)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (Start) begin
               state_d = ST_RUN;
               pc_d    = StartAddr;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            // A stalled cycle retires nothing, but HALT retires even if stalled.
            if ((Halt || !Stall) && (cnt_q != {CW{1'b1}})) begin
               cnt_d = cnt_q + CW'(1);
            end
            if (Halt) begin
               state_d = ST_HALTED;
            end else if (Stall) begin
               pc_d = pc_q;
            end else if (Jump) begin
               pc_d = jump_target;
            end else if (BranchEn && BranchTaken) begin
               pc_d = pc_q + PW'(1) + branch_ofs;
            end else begin
               pc_d = pc_q + PW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ProgCtr    = pc_q;
   assign InstrCount = cnt_q;
   assign Running    = (state_q == ST_RUN);
   assign Done       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a behavioural model
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int PW = 10;
   localparam int CW = 16;
   localparam int PC_MOD = 1 << PW;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic [PW-1:0] StartAddr;
   logic          Jump;
   logic          BranchEn;
   logic          BranchTaken;
   logic [4:0]    Imm;
   logic          Halt;
   logic          Stall;
   logic [PW-1:0] ProgCtr;
   logic          Running;
   logic          Done;
   logic [CW-1:0] InstrCount;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   // Model: 0 idle, 1 running, 2 halted; PC and count as plain integers.
   int m_mode = 0;
   int m_pc = 0;
   int m_cnt = 0;

   fetch_unit #(.PW(PW), .CW(CW)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .StartAddr   (StartAddr),
      .Jump        (Jump),
      .BranchEn    (BranchEn),
      .BranchTaken (BranchTaken),
      .Imm         (Imm),
      .Halt        (Halt),
      .Stall       (Stall),
      .ProgCtr     (ProgCtr),
      .Running     (Running),
      .Done        (Done),
      .InstrCount  (InstrCount)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int wrap_pc(input int v);
      return ((v % PC_MOD) + PC_MOD) % PC_MOD;
   endfunction

   always @(posedge Clk) begin
      if (!Reset) begin
         m_mode = 0;
         m_pc   = 0;
         m_cnt  = 0;
      end else if (m_mode == 1) begin
         if (Halt || !Stall) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
         if (Halt)                          m_mode = 2;
         else if (Stall)                    m_pc = m_pc;
         else if (Jump)                     m_pc = int'(jump_lut(Imm));
         else if (BranchEn && BranchTaken)  m_pc = wrap_pc(m_pc + 1 + int'(br_ofs(Imm[2:0])));
         else                               m_pc = wrap_pc(m_pc + 1);
      end else if (Start) begin
         m_mode = 1;
         m_pc   = int'(StartAddr);
         m_cnt  = 0;
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         chk("model_pc", int'(ProgCtr), m_pc);
         chk("model_running", int'(Running), (m_mode == 1) ? 1 : 0);
         chk("model_done", int'(Done), (m_mode == 2) ? 1 : 0);
         chk("model_count", int'(InstrCount), m_cnt);
      end
   end

   task automatic tick();
      @(negedge Clk);
   endtask

   task automatic clr();
      Start = 0; StartAddr = '0; Jump = 0; BranchEn = 0; BranchTaken = 0;
      Imm = '0; Halt = 0; Stall = 0;
   endtask

   task automatic start_at(input int addr);
      clr();
      Start = 1; StartAddr = PW'(addr);
      tick();
      Start = 0;
   endtask

   task automatic halt_now();
      clr();
      Halt = 1;
      tick();
      Halt = 0;
   endtask

   initial begin
      Reset = 0;
      clr();
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_pc", int'(ProgCtr), 0);
      chk("rst_running", int'(Running), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_count", int'(InstrCount), 0);

      Reset = 1;
      start_at(0);
      chk("start0_pc", int'(ProgCtr), 0);
      chk("start0_running", int'(Running), 1);
      tick(); chk("seq_pc1", int'(ProgCtr), 1);
      tick(); chk("seq_pc2", int'(ProgCtr), 2);
      tick(); chk("seq_pc3", int'(ProgCtr), 3);
      repeat (54) tick();
      chk("run_pc57", int'(ProgCtr), 57);

      // Reset mid-run wins over a simultaneous Start and Halt.
      Reset = 0; Start = 1; Halt = 1;
      tick();
      Start = 0; Halt = 0;
      tick();
      chk("midrst_pc", int'(ProgCtr), 0);
      chk("midrst_running", int'(Running), 0);
      chk("midrst_done", int'(Done), 0);
      chk("midrst_count", int'(InstrCount), 0);
      Reset = 1;

      start_at(20);
      Jump = 1; Imm = 5'd3;
      tick(); clr();
      chk("jump_pc100", int'(ProgCtr), 100);
      halt_now();
      chk("halt_done", int'(Done), 1);

      start_at(40);
      BranchEn = 1; BranchTaken = 1; Imm = 5'd1;
      tick(); clr();
      chk("br_taken_pc37", int'(ProgCtr), 37);
      repeat (3) tick();
      BranchEn = 1; BranchTaken = 0; Imm = 5'd1;
      tick(); clr();
      chk("br_not_taken_pc41", int'(ProgCtr), 41);
      BranchTaken = 1;
      tick(); clr();
      chk("bt_without_en_pc42", int'(ProgCtr), 42);

      halt_now();
      start_at(10);
      Stall = 1;
      repeat (3) tick();
      chk("stall_pc10", int'(ProgCtr), 10);
      chk("stall_count", int'(InstrCount), 0);
      Jump = 1; Imm = 5'd3;
      tick(); clr();
      chk("stall_jump_pc10", int'(ProgCtr), 10);
      tick();
      chk("unstall_pc11", int'(ProgCtr), 11);
      chk("unstall_count", int'(InstrCount), 1);

      halt_now();
      start_at(0);
      BranchEn = 1; BranchTaken = 1; Imm = 5'd3;
      tick(); clr();
      chk("self_branch_pc0", int'(ProgCtr), 0);
      repeat (15) tick();
      chk("pre_halt_pc15", int'(ProgCtr), 15);
      chk("pre_halt_count16", int'(InstrCount), 16);
      halt_now();
      chk("halted_pc15", int'(ProgCtr), 15);
      chk("halted_count17", int'(InstrCount), 17);
      chk("halted_done", int'(Done), 1);
      chk("halted_running", int'(Running), 0);
      tick();
      chk("halted_hold_count", int'(InstrCount), 17);
      start_at(200);
      chk("restart_pc200", int'(ProgCtr), 200);
      chk("restart_count0", int'(InstrCount), 0);
      chk("restart_done0", int'(Done), 0);

      halt_now();
      start_at(1022);
      chk("wrap_pc1022", int'(ProgCtr), 1022);
      tick(); chk("wrap_pc1023", int'(ProgCtr), 1023);
      tick(); chk("wrap_pc0", int'(ProgCtr), 0);
      tick(); chk("wrap_pc1", int'(ProgCtr), 1);
      BranchEn = 1; BranchTaken = 1; Imm = 5'd1;
      tick(); clr();
      chk("neg_wrap_pc1022", int'(ProgCtr), 1022);

      Halt = 1; Stall = 1; Jump = 1; Imm = 5'd3;
      tick(); clr();
      chk("combo_halt_pc", int'(ProgCtr), 1022);
      chk("combo_halt_done", int'(Done), 1);
      start_at(5);
      Start = 1; StartAddr = PW'(300);
      tick(); clr();
      chk("start_in_run_pc6", int'(ProgCtr), 6);
      chk("start_in_run_running", int'(Running), 1);
      tick();
      chk("start_in_run_pc7", int'(ProgCtr), 7);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
